sparam_sweep_sequencer: RTL and testbench

Sequences a multi-port S-parameter measurement of a passive network such as a 3-port Wilkinson divider. For each frequency point it drives each port in turn as the source, terminates the others, waits for settling, then handshakes with the receiver. It forwards one record per (frequency, source port) pair downstream. It sits between the host control registers and the source switch / receiver front end.

---
 rtl/sparam_seq_pkg.sv | 35 +++
 rtl/seq_down_timer.sv | 27 ++
 rtl/sparam_sweep_sequencer.sv | 178 +++++++++++++++++
 tb/tb_sparam_sweep_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparam_seq_pkg.sv
// rtl/sparam_seq_pkg.sv - shared types and defaults for the S-parameter sweep sequencer
package sparam_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT_ACK,
    S_EMIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  typedef logic [1:0] port_idx_t;

  localparam int DEF_NPORTS      = 3;
  localparam int DEF_FREQ_W      = 10;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef struct packed {
    logic [DEF_FREQ_W-1:0]            freq;
    port_idx_t                        src;
    logic [DEF_NPORTS*DEF_DATA_W-1:0] data;
  } record_t;

  // Timer holds at most max(a,b)-1, since loads are biased by one.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_down_timer.sv
// rtl/seq_down_timer.sv - loadable saturating down-counter with zero flag
module seq_down_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sparam_sweep_sequencer.sv
// rtl/sparam_sweep_sequencer.sv - steps frequency x source port, handshakes receiver, emits one record per pair
module sparam_sweep_sequencer
  import sparam_seq_pkg::*;
#(
  parameter int NPORTS      = DEF_NPORTS,
  parameter int FREQ_W      = DEF_FREQ_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [FREQ_W-1:0]        num_points,
  output logic [FREQ_W-1:0]        freq_idx,
  output logic [1:0]               src_port,
  output logic                     src_en,
  output logic                     meas_req,
  input  logic                     meas_ack,
  input  logic [NPORTS*DATA_W-1:0] meas_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FREQ_W-1:0]        out_freq,
  output logic [1:0]               out_src,
  output logic [NPORTS*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout
);

  localparam int TW = timer_width(SETTLE_CYC, TIMEOUT_CYC);
  // Loads are count-1 so that the zero flag marks the final cycle of each window.
  localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam port_idx_t     LAST_PORT    = port_idx_t'(NPORTS - 1);

  state_t            state, state_next;
  logic              timer_load, timer_dec, timer_zero;
  logic [TW-1:0]     timer_val;
  logic [FREQ_W-1:0] num_pts;
  logic              accept_start, capture, timeout_hit, last_rec, abort_hit;

  seq_down_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign abort_hit = abort && (state != S_IDLE);
  assign last_rec  = (freq_idx == (num_pts - FREQ_W'(1))) && (src_port == LAST_PORT);

  assign busy      = (state != S_IDLE);
  assign meas_req  = (state == S_REQ);
  assign out_valid = (state == S_EMIT);
  assign done      = (state == S_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    timer_load   = 1'b0;
    timer_val    = SETTLE_LOAD;
    timer_dec    = 1'b0;
    accept_start = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    if (abort_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            accept_start = 1'b1;
            if (num_points == '0) begin
              state_next = S_FINISH;
            end else begin
              timer_load = 1'b1;
              state_next = S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          // Timeout window opens with the request cycle itself.
          if (timer_zero) begin
            timer_load = 1'b1;
            timer_val  = TIMEOUT_LOAD;
            state_next = S_REQ;
          end else begin
            timer_dec = 1'b1;
          end
        end
        S_REQ: begin
          timer_dec  = 1'b1;
          state_next = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (meas_ack) begin
            capture    = 1'b1;
            state_next = S_EMIT;
          end else if (timer_zero) begin
            timeout_hit = 1'b1;
            state_next  = S_FINISH;
          end else begin
            timer_dec = 1'b1;
          end
        end
        S_EMIT: begin
          if (out_ready) state_next = S_ADVANCE;
        end
        S_ADVANCE: begin
          if (last_rec) begin
            state_next = S_FINISH;
          end else begin
            timer_load = 1'b1;
            state_next = S_SETTLE;
          end
        end
        S_FINISH: state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_pts     <= '0;
      freq_idx    <= '0;
      src_port    <= '0;
      src_en      <= 1'b0;
      out_freq    <= '0;
      out_src     <= '0;
      out_data    <= '0;
      err_timeout <= 1'b0;
    end else if (abort_hit) begin
      src_en   <= 1'b0;
      freq_idx <= '0;
      src_port <= '0;
    end else begin
      if (accept_start) begin
        num_pts     <= num_points;
        err_timeout <= 1'b0;
        freq_idx    <= '0;
        src_port    <= '0;
        src_en      <= (num_points != '0);
      end
      if (capture) begin
        out_freq <= freq_idx;
        out_src  <= src_port;
        out_data <= meas_data;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
        src_en      <= 1'b0;
      end
      if (state == S_ADVANCE) begin
        if (src_port == LAST_PORT) begin
          src_port <= '0;
          freq_idx <= freq_idx + FREQ_W'(1);
        end else begin
          src_port <= src_port + 2'd1;
        end
        if (last_rec) src_en <= 1'b0;
      end
      if (state == S_FINISH) begin
        freq_idx <= '0;
        src_port <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sparam_sweep_sequencer.sv
// tb/tb_sparam_sweep_sequencer.sv - directed self-checking bench for sparam_sweep_sequencer
module tb_sparam_sweep_sequencer;

  localparam int NPORTS = 3;
  localparam int FREQ_W = 10;
  localparam int DATA_W = 16;

  logic                     clk, rst_n, start, abort, meas_ack, out_ready;
  logic [FREQ_W-1:0]        num_points, freq_idx, out_freq;
  logic [1:0]               src_port, out_src;
  logic                     src_en, meas_req, out_valid, busy, done, err_timeout;
  logic [NPORTS*DATA_W-1:0] meas_data, out_data;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int n, r0, d0;

  sparam_sweep_sequencer #(
    .NPORTS(NPORTS), .FREQ_W(FREQ_W), .DATA_W(DATA_W), .SETTLE_CYC(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_points(num_points),
    .freq_idx(freq_idx), .src_port(src_port), .src_en(src_en), .meas_req(meas_req),
    .meas_ack(meas_ack), .meas_data(meas_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_freq(out_freq), .out_src(out_src), .out_data(out_data), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_req === 1'b1) req_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rec_data(input int f, input int s);
    return {16'(32'hC000 + f * 16 + s), 16'(32'hB000 + f * 16 + s), 16'(32'hA000 + f * 16 + s)};
  endfunction

  // Entered on the first SETTLE cycle of a point; returns on its ADVANCE cycle.
  task automatic do_record(input int f, input int s, input int dly, input bit poke);
    int m;
    logic [47:0] d;
    d = rec_data(f, s);
    if (poke) begin
      start = 1'b1;
      num_points = 10'd5;
    end
    m = 0;
    while (meas_req !== 1'b1 && m < 40) begin
      tick();
      start = 1'b0;
      m++;
    end
    check("settle_len", 64'(m), 64'(4));
    check("req_freq", 64'(freq_idx), 64'(f));
    check("req_src", 64'(src_port), 64'(s));
    meas_ack = 1'b1;
    meas_data = ~d;
    tick();
    meas_ack = 1'b0;
    check("req_pulse", 64'(meas_req), 64'(0));
    tick();
    tick();
    meas_ack = 1'b1;
    meas_data = d;
    check("early_ack", 64'(out_valid), 64'(0));
    tick();
    meas_ack = 1'b0;
    out_ready = (dly == 0);
    check("emit_valid", 64'(out_valid), 64'(1));
    check("out_freq", 64'(out_freq), 64'(f));
    check("out_src", 64'(out_src), 64'(s));
    check("out_data", 64'(out_data), 64'(d));
    for (int k = 1; k <= dly; k++) begin
      tick();
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_data", 64'(out_data), 64'(d));
      check("bp_req", 64'(meas_req), 64'(0));
      if (k == dly) out_ready = 1'b1;
    end
    tick();
    check("adv_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; meas_ack = 1'b0; out_ready = 1'b1;
    num_points = '0; meas_data = '0;
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_src_en", 64'(src_en), 64'(0));
    check("rst_req", 64'(meas_req), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    check("rst_freq", 64'(freq_idx), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    rst_n = 1'b1;
    tick();

    // Full sweep, backpressure on first record, stray start during second.
    r0 = req_cnt; d0 = done_cnt;
    start = 1'b1; num_points = 10'd2;
    tick();
    start = 1'b0;
    check("sweep_src_en", 64'(src_en), 64'(1));
    for (int i = 0; i < 6; i++) begin
      do_record(i / 3, i % 3, (i == 0) ? 10 : 0, i == 1);
      tick();
    end
    check("sweep_done", 64'(done), 64'(1));
    check("sweep_src_off", 64'(src_en), 64'(0));
    tick();
    check("sweep_done_drop", 64'(done), 64'(0));
    check("sweep_idle", 64'(busy), 64'(0));
    check("sweep_freq_rst", 64'(freq_idx), 64'(0));
    check("sweep_req_cnt", 64'(req_cnt - r0), 64'(6));
    check("sweep_done_cnt", 64'(done_cnt - d0), 64'(1));

    // Ack timeout.
    start = 1'b1; num_points = 10'd1;
    tick();
    start = 1'b0;
    n = 0;
    while (meas_req !== 1'b1 && n < 40) begin tick(); n++; end
    check("to_settle_len", 64'(n), 64'(4));
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check("to_err_early", 64'(err_timeout), 64'(0));
    end
    check("to_err", 64'(err_timeout), 64'(1));
    check("to_done", 64'(done), 64'(1));
    check("to_src_off", 64'(src_en), 64'(0));
    tick();
    check("to_idle", 64'(busy), 64'(0));
    check("to_err_sticky", 64'(err_timeout), 64'(1));
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_idle", 64'(busy), 64'(0));
    check("sa_err_kept", 64'(err_timeout), 64'(1));

    // Zero-point sweep clears the sticky error.
    r0 = req_cnt;
    start = 1'b1; num_points = 10'd0;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'(1));
    check("zero_err_clr", 64'(err_timeout), 64'(0));
    tick();
    check("zero_idle", 64'(busy), 64'(0));
    check("zero_no_req", 64'(req_cnt - r0), 64'(0));

    // Abort while waiting for the (1,2) ack.
    d0 = done_cnt;
    start = 1'b1; num_points = 10'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_record(i / 3, i % 3, 0, 1'b0);
      tick();
    end
    n = 0;
    while (meas_req !== 1'b1 && n < 40) begin tick(); n++; end
    check("ab_settle_len", 64'(n), 64'(4));
    check("ab_src", 64'(src_port), 64'(2));
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_src_en", 64'(src_en), 64'(0));
    check("ab_busy", 64'(busy), 64'(0));
    check("ab_req", 64'(meas_req), 64'(0));
    meas_ack = 1'b1;
    meas_data = rec_data(1, 2);
    tick();
    meas_ack = 1'b0;
    check("ab_no_rec", 64'(out_valid), 64'(0));
    tick();
    check("ab_no_done", 64'(done_cnt - d0), 64'(0));

    // Asynchronous reset while a record is held in EMIT.
    start = 1'b1; num_points = 10'd1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (meas_req !== 1'b1 && n < 40) begin tick(); n++; end
    tick(); tick(); tick();
    meas_ack = 1'b1;
    meas_data = rec_data(0, 0);
    tick();
    meas_ack = 1'b0;
    check("re_emit", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("re_valid", 64'(out_valid), 64'(0));
    check("re_busy", 64'(busy), 64'(0));
    check("re_src_en", 64'(src_en), 64'(0));
    check("re_data", 64'(out_data), 64'(0));
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b1; num_points = 10'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_record(0, i, 0, 1'b0);
      tick();
    end
    check("re_done", 64'(done), 64'(1));
    tick();
    check("re_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
